// File: rtl/taxi_disp_pkg.sv
// Shared encodings for the taximeter display scheduler: mux selects, FSM states, advance order.
package taxi_disp_pkg;

    localparam logic [1:0] OP_MIL  = 2'b00;
    localparam logic [1:0] OP_TIME = 2'b01;
    localparam logic [1:0] OP_COST = 2'b10;

    localparam logic [1:0] S_AUTO      = 2'b00;
    localparam logic [1:0] S_MANUAL    = 2'b01;
    localparam logic [1:0] S_FARE_HOLD = 2'b10;

    // Rotation order mileage -> time -> cost -> mileage; 11 never leaves this function.
    function automatic logic [1:0] next_op(input logic [1:0] op);
        case (op)
            OP_MIL:  next_op = OP_TIME;
            OP_TIME: next_op = OP_COST;
            default: next_op = OP_MIL;
        endcase
    endfunction

endpackage

// File: rtl/taxi_key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level debounce, one-cycle rising-edge pulse.
module taxi_key_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_rise
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          filt;
    logic [CW-1:0] count;

    // The filtered level only flips after DEB_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            filt     <= 1'b0;
            count    <= '0;
            key_rise <= 1'b0;
        end else begin
            sync1    <= key_raw;
            sync2    <= sync1;
            key_rise <= 1'b0;
            if (sync2 == filt) begin
                count <= '0;
            end else if (count == DEB_LAST) begin
                count    <= '0;
                filt     <= sync2;
                key_rise <= sync2;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/taxi_disp_sched.sv
// Taximeter 7-seg scheduler: digit-scan prescaler plus the op rotation FSM (auto, manual, fare hold).
module taxi_disp_sched
    import taxi_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DWELL_FRAMES = 750,
    parameter int DEB_CYCLES   = 500000,
    parameter int FARE_FRAMES  = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_next,
    input  logic       auto_en,
    input  logic       trip_active,
    output logic [1:0] op,
    output logic [2:0] cnt,
    output logic       scan_tick,
    output logic       op_change,
    output logic       hold_active
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DWELL_FRAMES + 1);
    localparam int HW = $clog2(FARE_FRAMES + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(FARE_FRAMES - 1);

    logic [PW-1:0] pre;
    logic [DW-1:0] dwell;
    logic [HW-1:0] holdcnt;
    logic [1:0]    state;
    logic          key_rise;
    logic          key_pend;
    logic          end_pend;
    logic          trip_q;
    logic          trip_fall;
    logic          fb;
    logic          key_now;
    logic          end_now;

    taxi_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_debounce (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_next),
        .key_rise (key_rise)
    );

    // An event arriving on the boundary cycle itself is consumed by that boundary.
    assign scan_tick   = (pre == PRE_LAST);
    assign fb          = scan_tick && (cnt == 3'd3);
    assign trip_fall   = trip_q && !trip_active;
    assign key_now     = key_pend || key_rise;
    assign end_now     = end_pend || trip_fall;
    assign hold_active = (state == S_FARE_HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            cnt <= '0;
        end else if (scan_tick) begin
            pre <= '0;
            cnt <= (cnt == 3'd3) ? 3'd0 : cnt + 3'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op        <= OP_MIL;
            op_change <= 1'b0;
            state     <= S_AUTO;
            dwell     <= '0;
            holdcnt   <= '0;
            key_pend  <= 1'b0;
            end_pend  <= 1'b0;
            trip_q    <= 1'b0;
        end else begin
            op_change <= 1'b0;
            trip_q    <= trip_active;
            if (fb) begin
                key_pend <= 1'b0;
                end_pend <= 1'b0;
            end else begin
                if (key_rise)  key_pend <= 1'b1;
                if (trip_fall) end_pend <= 1'b1;
            end

            if (!fb) begin
                if (state == S_AUTO && !auto_en)
                    state <= S_MANUAL;
                else if (state == S_MANUAL && auto_en)
                    state <= S_AUTO;
            end else if (state == S_FARE_HOLD) begin
                if (end_now) begin
                    holdcnt <= '0;
                end else if (key_now || holdcnt == HOLD_LAST) begin
                    state   <= auto_en ? S_AUTO : S_MANUAL;
                    dwell   <= '0;
                    holdcnt <= '0;
                end else begin
                    holdcnt <= holdcnt + HW'(1);
                end
            end else if (end_now) begin
                op        <= OP_COST;
                op_change <= (op != OP_COST);
                state     <= S_FARE_HOLD;
                holdcnt   <= '0;
            end else begin
                // Mode follows auto_en at the boundary too, so the rules below use the live mode.
                state <= auto_en ? S_AUTO : S_MANUAL;
                if (key_now) begin
                    op        <= next_op(op);
                    op_change <= 1'b1;
                    if (auto_en) dwell <= '0;
                end else if (!auto_en) begin
                    dwell <= '0;
                end else if (dwell == DWELL_LAST) begin
                    op        <= next_op(op);
                    op_change <= 1'b1;
                    dwell     <= '0;
                end else begin
                    dwell <= dwell + DW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_taxi_disp_sched.sv
// Scenario bench for taxi_disp_sched with a small-parameter build (frame = 16 clk).
module tb_taxi_disp_sched;
    import taxi_disp_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_next = 1'b0;
    logic       auto_en = 1'b1;
    logic       trip_active = 1'b0;
    logic [1:0] op;
    logic [2:0] cnt;
    logic       scan_tick;
    logic       op_change;
    logic       hold_active;

    taxi_disp_sched #(
        .SCAN_DIV(4), .DWELL_FRAMES(3), .DEB_CYCLES(5), .FARE_FRAMES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_next    (key_next),
        .auto_en     (auto_en),
        .trip_active (trip_active),
        .op          (op),
        .cnt         (cnt),
        .scan_tick   (scan_tick),
        .op_change   (op_change),
        .hold_active (hold_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int base = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int         at;
        logic [1:0] op;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every op_change pulse must match the next expected (cycle, op).
    always @(negedge clk) begin
        if (!rst && op_change) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL op_change_unexpected: pulse at cycle %0d op=%b, none expected", cyc - base, op);
            end else begin
                e = sb.pop_front();
                if (e.at !== cyc || e.op !== op)
                    $display("FAIL op_change: cycle %0d op=%b, expected cycle %0d op=%b",
                             cyc - base, op, e.at - base, e.op);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic goto(input int r);
        while ((cyc - base) < r) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int r, input logic [1:0] o);
        sb.push_back('{base + r, o});
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({op, cnt, scan_tick, op_change, hold_active} !== 8'b0)
            $display("FAIL reset_outputs: op=%b cnt=%0d tick=%b chg=%b hold=%b, expected all 0",
                     op, cnt, scan_tick, op_change, hold_active);
        else n_pass++;
        rst  = 1'b0;
        base = cyc;
    endtask

    task automatic test_auto_rotation;
        push(48, OP_TIME);
        push(96, OP_COST);
        push(144, OP_MIL);
        for (int r = 0; r < 20; r++) begin
            goto(r);
            n_total++;
            if (scan_tick !== (r % 4 == 3))
                $display("FAIL scan_tick: cycle %0d got %b, expected %b", r, scan_tick, (r % 4 == 3));
            else n_pass++;
            n_total++;
            if (cnt !== 3'((r / 4) % 4))
                $display("FAIL cnt_seq: cycle %0d got %0d, expected %0d", r, cnt, (r / 4) % 4);
            else n_pass++;
        end
        goto(150);
        n_total++;
        if (sb.size() !== 0 || op !== OP_MIL)
            $display("FAIL auto_done: pending=%0d op=%b, expected 0 pending op=00", sb.size(), op);
        else n_pass++;
    endtask

    task automatic test_manual_key;
        goto(160);
        auto_en  = 1'b0;
        key_next = 1'b1;
        push(176, OP_TIME);
        goto(168);
        key_next = 1'b0;
        goto(176);
        key_next = 1'b1;
        goto(179);
        key_next = 1'b0;
        goto(200);
        n_total++;
        if (op !== OP_TIME)
            $display("FAIL glitch_no_advance: op=%b, expected 01", op);
        else n_pass++;
        goto(204);
        key_next = 1'b1;
        goto(209);
        key_next = 1'b0;
        goto(214);
        key_next = 1'b1;
        push(224, OP_COST);
        goto(219);
        key_next = 1'b0;
        goto(250);
        n_total++;
        if (sb.size() !== 0 || op !== OP_COST)
            $display("FAIL two_presses_one_advance: pending=%0d op=%b, expected 0 pending op=10", sb.size(), op);
        else n_pass++;
    endtask

    task automatic test_fare_hold;
        goto(256);
        auto_en     = 1'b1;
        trip_active = 1'b1;
        push(304, OP_MIL);
        push(352, OP_TIME);
        goto(356);
        trip_active = 1'b0;
        push(368, OP_COST);
        goto(370);
        n_total++;
        if (hold_active !== 1'b1 || op !== OP_COST)
            $display("FAIL hold_enter: hold=%b op=%b, expected 1 and 10", hold_active, op);
        else n_pass++;
        goto(430);
        n_total++;
        if (hold_active !== 1'b1)
            $display("FAIL hold_last_frame: hold=%b, expected 1", hold_active);
        else n_pass++;
        goto(433);
        n_total++;
        if (hold_active !== 1'b0 || op !== OP_COST)
            $display("FAIL hold_exit: hold=%b op=%b, expected 0 and 10", hold_active, op);
        else n_pass++;
        push(480, OP_MIL);
        goto(479);
        n_total++;
        if (op !== OP_COST)
            $display("FAIL post_hold_dwell: op=%b, expected 10", op);
        else n_pass++;
        goto(482);
        n_total++;
        if (sb.size() !== 0)
            $display("FAIL fare_hold_events: pending=%0d, expected 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_hold_key_exit;
        trip_active = 1'b1;
        goto(485);
        trip_active = 1'b0;
        push(496, OP_COST);
        goto(500);
        key_next = 1'b1;
        goto(506);
        key_next = 1'b0;
        goto(510);
        n_total++;
        if (hold_active !== 1'b1)
            $display("FAIL key_hold_before: hold=%b, expected 1", hold_active);
        else n_pass++;
        goto(513);
        n_total++;
        if (hold_active !== 1'b0 || op !== OP_COST)
            $display("FAIL key_hold_exit: hold=%b op=%b, expected 0 and 10", hold_active, op);
        else n_pass++;
        push(560, OP_MIL);
    endtask

    task automatic test_simul_end_key;
        goto(561);
        trip_active = 1'b1;
        goto(562);
        key_next = 1'b1;
        goto(566);
        trip_active = 1'b0;
        push(576, OP_COST);
        goto(568);
        key_next = 1'b0;
        goto(578);
        n_total++;
        if (hold_active !== 1'b1 || op !== OP_COST)
            $display("FAIL simul_end_wins: hold=%b op=%b, expected 1 and 10", hold_active, op);
        else n_pass++;
        goto(592);
        trip_active = 1'b1;
        goto(595);
        trip_active = 1'b0;
        goto(660);
        n_total++;
        if (hold_active !== 1'b1)
            $display("FAIL hold_restart: hold=%b, expected 1", hold_active);
        else n_pass++;
        goto(673);
        n_total++;
        if (hold_active !== 1'b0 || op !== OP_COST || sb.size() !== 0)
            $display("FAIL restart_exit: hold=%b op=%b pending=%0d, expected 0, 10, 0",
                     hold_active, op, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold;
        goto(674);
        trip_active = 1'b1;
        goto(677);
        trip_active = 1'b0;
        goto(690);
        n_total++;
        if (hold_active !== 1'b1)
            $display("FAIL rehold: hold=%b, expected 1", hold_active);
        else n_pass++;
        goto(697);
        n_total++;
        if (cnt !== 3'd2)
            $display("FAIL pre_reset_cnt: cnt=%0d, expected 2", cnt);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (op !== OP_MIL || cnt !== 3'd0 || hold_active !== 1'b0 || scan_tick !== 1'b0)
            $display("FAIL async_reset: op=%b cnt=%0d hold=%b tick=%b, expected 00 0 0 0",
                     op, cnt, hold_active, scan_tick);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
        push(48, OP_TIME);
        for (int r = 0; r < 5; r++) begin
            goto(r);
            n_total++;
            if (scan_tick !== (r == 3))
                $display("FAIL first_tick: cycle %0d got %b, expected %b", r, scan_tick, (r == 3));
            else n_pass++;
        end
        goto(50);
        n_total++;
        if (sb.size() !== 0 || op !== OP_TIME)
            $display("FAIL post_reset_rotation: pending=%0d op=%b, expected 0 and 01", sb.size(), op);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_auto_rotation();
        test_manual_key();
        test_fare_hold();
        test_hold_key_exit();
        test_simul_end_key();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
